pipeline_stage_chain: RTL and testbench
=======================================

Name: pipeline_stage_chain

Overview:
- Parametrised chain of pipeline registers carrying a data word plus a valid bit through STAGES stages.
- Each stage has its own stall (hold) and flush (bubble) control, and backpressure propagates toward the input.
- Successor to the fixed, always-enabled, untagged stage registers between IF/ID/EX/MEM/WB. Hazard and branch logic drive stall/flush directly.
- Includes saturating occupancy and stall statistics for debug.

Parameters:
- STAGES, 4, number of register stages; minimum 1.
- DATA_WIDTH, 32, width of the payload per stage.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  producer presents an item
- in_data  input  DATA_WIDTH  producer payload
- in_ready  output  1  stage 0 accepts this cycle
- stall_mask  input  STAGES  bit i forces stage i to hold
- flush_mask  input  STAGES  bit i turns stage i into a bubble next cycle
- out_ready  input  1  consumer accepts the last stage
- out_valid  output  1  valid bit of the last stage
- out_data  output  DATA_WIDTH  payload of the last stage
- stage_valid  output  STAGES  valid bit of every stage
- stage_data  output  STAGES*DATA_WIDTH  all payloads flattened, stage 0 in the LSBs
- occupancy  output  $clog2(STAGES+1)  count of valid stages
- retired_count  output  CNT_WIDTH  items consumed at the output
- stall_count  output  CNT_WIDTH  cycles with in_valid=1 and in_ready=0

Behaviour:
- Reset (reset=0, asynchronous):
  - all valid bits, all data, occupancy, retired_count and stall_count go to 0.
  - in_ready=1 immediately; out_valid=0.
  - Reset asserted mid-transfer drops all items in flight; no partial state survives.
- Hold equation, combinational, evaluated from last stage to first:
  - hold[S-1] = stall_mask[S-1] | (valid[S-1] & ~out_ready)
  - hold[i] = stall_mask[i] | (valid[i] & hold[i+1])
  - A held stage that is empty does not block its predecessor: bubbles collapse.
  - The chain is combinational from out_ready and stall_mask to in_ready, with no registered skid.
- Next state per stage i, at the rising edge:
  - flush_mask[i]=1: valid=0, data=0. Highest priority, overrides hold.
  - else if hold[i]: contents unchanged.
  - else: load stage i-1. For stage 0, load in_valid/in_data.
  - If stage i-1 is itself held, stage i loads a bubble (valid=0, data=0).
  - Flushing stage i-1 does not alter what stage i receives in that same cycle; the flush affects only i-1's next value.
- Handshakes:
  - in_ready = ~hold[0]. The item is accepted when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready & ~stall_mask[S-1].
  - out_data is stable while out_valid=1 and the transfer has not occurred, unless stage S-1 is flushed.
- Latency: an item accepted at cycle t appears at the output at t+STAGES, with no stalls.
- Throughput: 1 item/cycle.
- Payload width: data is passed through unmodified; no width conversion.
- Counters:
  - occupancy is registered and equals the popcount of the valid bits after each edge.
  - retired_count increments on each output transfer.
  - stall_count increments on each cycle with in_valid & ~in_ready.
  - Both counters saturate at all-ones and never wrap.
- Simultaneous events:
  - flush and stall on the same stage: flush wins.
  - flush on the last stage while out_ready=1: no transfer is counted.
- STAGES=1: the chain degenerates to a single register with the same rules.

Decomposition:
- Shared package pipeline_pkg:
  - default DATA_WIDTH/STAGES/CNT_WIDTH constants
  - the bubble value (all zeros, equal to the MIPS nop encoding)
  - a saturating-increment function
- Sub-module pipe_stage: one stage register holding valid+data.
  - Inputs: hold, flush, upstream valid/data, upstream hold.
  - Implements the next-state priority above.
  - The top level instantiates it STAGES times in a generate loop and owns the hold chain and counters.

Test Plan:
- Reset, then stream values 1..8 on consecutive cycles with out_ready=1 and no masks -> out_data=1 at cycle 4; values 1..8 appear on consecutive cycles; retired_count=8; occupancy peaks at 4.
- Full pipe (4 valid), out_ready=0 for 3 cycles -> in_ready=0; contents frozen; stall_count +3 while in_valid=1; release -> no loss or duplication.
- stall_mask=4'b0010 for 2 cycles during streaming with stage 1 valid and stage 0 valid -> stage 0 holds, stage 2 receives bubbles, in_ready=0; order is preserved after release.
- flush_mask=4'b0011 on one cycle (branch taken) with stages 0-1 holding 0xA,0xB -> both become valid=0/data=0; 0xB still reaches stage 2; occupancy drops by 2.
- flush_mask[3]=1 and stall_mask[3]=1 together with out_ready=1 -> stage 3 is emptied; retired_count unchanged.
- Drive reset=0 asynchronously mid-stream, between clock edges -> all outputs zero before the next edge; counters drive 0xFFFF at saturation before the reset and 0 after it.

Source files
------------

// File: rtl/pipeline_stage_chain_pkg.sv
// Shared constants and helpers for the stall/flush-aware pipeline register chain.
package pipeline_pkg;

  localparam int DEF_STAGES     = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;

  // A bubble is an all-zero word, which doubles as the MIPS nop encoding.
  localparam logic BUBBLE_BIT = 1'b0;

  // Saturating increment for counters up to 63 bits wide; the caller slices the result.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/pipeline_stage_chain_if.sv
// Producer/consumer handshake bundle for the pipeline chain.
interface pipeline_stage_chain_if
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipeline_stage_chain_stage.sv
// One pipeline register (valid + payload) with flush > hold > load priority.
module pipe_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  up_hold,
  output logic                  valid,
  output logic                  valid_nxt,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  valid_d, valid_q;
  logic [DATA_WIDTH-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = BUBBLE_BIT;
      data_d  = {DATA_WIDTH{BUBBLE_BIT}};
    end else if (!hold) begin
      // A held predecessor keeps its item, so this slot takes a bubble instead.
      if (up_hold) begin
        valid_d = BUBBLE_BIT;
        data_d  = {DATA_WIDTH{BUBBLE_BIT}};
      end else begin
        valid_d = up_valid;
        data_d  = up_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid     = valid_q;
  assign valid_nxt = valid_d;
  assign data      = data_q;

endmodule

// File: rtl/pipeline_stage_chain.sv
// Parametrised chain of stall/flush-controlled pipeline stages with debug statistics.
module pipeline_stage_chain
  import pipeline_pkg::*;
#(
  parameter int STAGES     = DEF_STAGES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  localparam int OCC_W     = $clog2(STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_stage_chain_if.slave        pipe,
  input  logic [STAGES-1:0]            stall_mask,
  input  logic [STAGES-1:0]            flush_mask,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*DATA_WIDTH-1:0] stage_data,
  output logic [OCC_W-1:0]             occupancy,
  output logic [CNT_WIDTH-1:0]         retired_count,
  output logic [CNT_WIDTH-1:0]         stall_count
);

  logic [STAGES-1:0]                 valid, valid_nxt, hold;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data;
  logic                              hold_run;
  logic                              xfer;

  logic [OCC_W-1:0]       occ_d, occ_q;
  logic [CNT_WIDTH-1:0]   retired_d, retired_q;
  logic [CNT_WIDTH-1:0]   stall_cnt_d, stall_cnt_q;
  logic [63-CNT_WIDTH:0]  ret_unused_hi, stl_unused_hi;

  // Backpressure ripples from the consumer toward the producer; empty stages absorb it.
  always_comb begin
    hold     = '0;
    hold_run = stall_mask[STAGES-1] | (valid[STAGES-1] & ~pipe.out_ready);
    hold[STAGES-1] = hold_run;
    for (int i = STAGES - 2; i >= 0; i--) begin
      hold_run = stall_mask[i] | (valid[i] & hold_run);
      hold[i]  = hold_run;
    end
  end

  assign pipe.in_ready  = ~reset | ~hold[0];
  assign pipe.out_valid = valid[STAGES-1];
  assign pipe.out_data  = data[STAGES-1];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold[g]),
        .flush     (flush_mask[g]),
        .up_valid  (pipe.in_valid),
        .up_data   (pipe.in_data),
        .up_hold   (1'b0),
        .valid     (valid[g]),
        .valid_nxt (valid_nxt[g]),
        .data      (data[g])
      );
    end else begin : g_rest
      pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold[g]),
        .flush     (flush_mask[g]),
        .up_valid  (valid[g-1]),
        .up_data   (data[g-1]),
        .up_hold   (hold[g-1]),
        .valid     (valid[g]),
        .valid_nxt (valid_nxt[g]),
        .data      (data[g])
      );
    end
  end

  // A flushed last stage never counts as delivered, even with the consumer ready.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OCC_W'(valid_nxt[i]);
    end
    xfer = valid[STAGES-1] & pipe.out_ready & ~stall_mask[STAGES-1] & ~flush_mask[STAGES-1];

    {ret_unused_hi, retired_d} = xfer ? sat_inc(64'(retired_q), CNT_WIDTH) : 64'(retired_q);
    {stl_unused_hi, stall_cnt_d} = (pipe.in_valid & hold[0]) ?
                                   sat_inc(64'(stall_cnt_q), CNT_WIDTH) : 64'(stall_cnt_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q       <= '0;
      retired_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      occ_q       <= occ_d;
      retired_q   <= retired_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stage_valid   = valid;
  assign stage_data    = data;
  assign occupancy     = occ_q;
  assign retired_count = retired_q;
  assign stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Directed + randomized bench for pipeline_stage_chain (4-stage/16-bit and 1-stage/4-bit instances).
module tb_pipeline_stage_chain;

  localparam int DW = 32;

  logic clk;
  logic reset;

  pipeline_stage_chain_if #(.DATA_WIDTH(DW)) if0 ();
  pipeline_stage_chain_if #(.DATA_WIDTH(DW)) if1 ();

  logic [3:0]   stall0, flush0, sv0;
  logic [127:0] sd0;
  logic [2:0]   occ0;
  logic [15:0]  ret0, stc0;

  logic [0:0]   stall1, flush1, sv1, occ1;
  logic [31:0]  sd1;
  logic [3:0]   ret1, stc1;

  pipeline_stage_chain #(.STAGES(4), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .pipe(if0), .stall_mask(stall0), .flush_mask(flush0),
    .stage_valid(sv0), .stage_data(sd0), .occupancy(occ0),
    .retired_count(ret0), .stall_count(stc0)
  );

  pipeline_stage_chain #(.STAGES(1), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .reset(reset), .pipe(if1), .stall_mask(stall1), .flush_mask(flush1),
    .stage_valid(sv1), .stage_data(sd1), .occupancy(occ1),
    .retired_count(ret1), .stall_count(stc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic [3:0]  stl;
    logic [3:0]  fl;
  } drv_t;

  drv_t        drv[2];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mv[2][4];
  logic [31:0] md[2][4];
  bit          mh[2][4];
  bit          ir_e[2];
  int          mret[2];
  int          mstl[2];
  int          ms[2]   = '{4, 1};
  int          cmax[2] = '{65535, 15};

  bit          order_on;
  int          exp_next, n_xfer, prod, peak;
  logic        obs_ir0, obs_x;
  logic [31:0] obs_xd;

  task automatic chk(int m, string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL dut%0d %s: observed %0h expected %0h", m, tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int m = 0; m < 2; m++) begin
      drv[m].iv = 1'b0; drv[m].id = '0; drv[m].ordy = 1'b1;
      drv[m].stl = '0; drv[m].fl = '0;
    end
  endtask

  task automatic apply();
    if0.in_valid = drv[0].iv; if0.in_data = drv[0].id; if0.out_ready = drv[0].ordy;
    stall0 = drv[0].stl; flush0 = drv[0].fl;
    if1.in_valid = drv[1].iv; if1.in_data = drv[1].id; if1.out_ready = drv[1].ordy;
    stall1 = drv[1].stl[0:0]; flush1 = drv[1].fl[0:0];
  endtask

  task automatic model_reset(int m);
    for (int i = 0; i < 4; i++) begin mv[m][i] = 1'b0; md[m][i] = '0; end
    mret[m] = 0; mstl[m] = 0;
  endtask

  // A stage is stuck if, looking downstream through a run of occupied stages,
  // we meet a stall or reach a full last stage the consumer will not take.
  function automatic bit held(int m, int i);
    bit res = 1'b0;
    bit done = 1'b0;
    for (int j = i; j < ms[m]; j++) begin
      if (!done) begin
        if (drv[m].stl[j]) begin res = 1'b1; done = 1'b1; end
        else if (!mv[m][j]) begin res = 1'b0; done = 1'b1; end
        else if (j == ms[m] - 1) begin res = !drv[m].ordy; done = 1'b1; end
      end
    end
    return res;
  endfunction

  task automatic model_pre(int m);
    for (int i = 0; i < ms[m]; i++) mh[m][i] = held(m, i);
    ir_e[m] = !mh[m][0];
  endtask

  task automatic model_edge(int m);
    int          s;
    bit          nv[4];
    logic [31:0] nd[4];
    s = ms[m];
    if (mv[m][s-1] && drv[m].ordy && !drv[m].stl[s-1] && !drv[m].fl[s-1] && mret[m] < cmax[m])
      mret[m]++;
    if (drv[m].iv && mh[m][0] && mstl[m] < cmax[m]) mstl[m]++;
    for (int i = 0; i < s; i++) begin
      nv[i] = mv[m][i]; nd[i] = md[m][i];
      if (drv[m].fl[i]) begin nv[i] = 1'b0; nd[i] = '0; end
      else if (!mh[m][i]) begin
        if (i == 0) begin nv[i] = drv[m].iv; nd[i] = drv[m].id; end
        else if (mh[m][i-1]) begin nv[i] = 1'b0; nd[i] = '0; end
        else begin nv[i] = mv[m][i-1]; nd[i] = md[m][i-1]; end
      end
    end
    for (int i = 0; i < s; i++) begin mv[m][i] = nv[i]; md[m][i] = nd[i]; end
  endtask

  task automatic check_state(int m);
    logic [3:0]   ev;
    logic [127:0] ed;
    int           eocc, s;
    s = ms[m]; ev = '0; ed = '0; eocc = 0;
    for (int i = 0; i < s; i++) begin
      ev[i] = mv[m][i]; ed[32*i +: 32] = md[m][i]; eocc += int'(mv[m][i]);
    end
    if (m == 0) begin
      chk(0, "stage_valid", 128'(sv0), 128'(ev));
      chk(0, "stage_data", sd0, ed);
      chk(0, "occupancy", 128'(occ0), 128'(eocc));
      chk(0, "out_valid", 128'(if0.out_valid), 128'(mv[0][3]));
      chk(0, "out_data", 128'(if0.out_data), 128'(md[0][3]));
      chk(0, "retired_count", 128'(ret0), 128'(mret[0]));
      chk(0, "stall_count", 128'(stc0), 128'(mstl[0]));
    end else begin
      chk(1, "stage_valid", 128'(sv1), 128'(ev));
      chk(1, "stage_data", 128'(sd1), ed);
      chk(1, "occupancy", 128'(occ1), 128'(eocc));
      chk(1, "out_valid", 128'(if1.out_valid), 128'(mv[1][0]));
      chk(1, "out_data", 128'(if1.out_data), 128'(md[1][0]));
      chk(1, "retired_count", 128'(ret1), 128'(mret[1]));
      chk(1, "stall_count", 128'(stc1), 128'(mstl[1]));
    end
  endtask

  // Called at posedge+1: drive, settle, check combinational ready, clock, check state.
  task automatic step();
    apply();
    #1;
    model_pre(0); model_pre(1);
    chk(0, "in_ready", 128'(if0.in_ready), 128'(ir_e[0]));
    chk(1, "in_ready", 128'(if1.in_ready), 128'(ir_e[1]));
    obs_ir0 = if0.in_ready;
    obs_x   = if0.out_valid & drv[0].ordy & ~drv[0].stl[3] & ~drv[0].fl[3];
    obs_xd  = if0.out_data;
    @(posedge clk);
    #1;
    model_edge(0); model_edge(1);
    check_state(0); check_state(1);
    if (obs_x) begin
      n_xfer++;
      if (order_on) begin
        chk(0, "order", 128'(obs_xd), 128'(exp_next));
        exp_next++;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    idle(); apply();
    model_reset(0); model_reset(1);
    #12;
    check_state(0); check_state(1);
    chk(0, "reset in_ready", 128'(if0.in_ready), 128'(1));
    chk(1, "reset in_ready", 128'(if1.in_ready), 128'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Stream 1..8 with a free consumer: four-cycle latency, back-to-back output.
    order_on = 1'b1; exp_next = 1; n_xfer = 0; peak = 0;
    for (int k = 1; k <= 12; k++) begin
      drv[0].iv = (k <= 8); drv[0].id = 32'(k);
      step();
      if (int'(occ0) > peak) peak = int'(occ0);
      if (k == 3) chk(0, "latency early", 128'(if0.out_valid), 128'(0));
      if (k >= 4 && k <= 11) begin
        chk(0, "stream out_valid", 128'(if0.out_valid), 128'(1));
        chk(0, "stream out_data", 128'(if0.out_data), 128'(k - 3));
      end
    end
    chk(0, "stream transfers", 128'(n_xfer), 128'(8));
    chk(0, "stream retired", 128'(ret0), 128'(8));
    chk(0, "stream peak occ", 128'(peak), 128'(4));

    // Fill, then block the consumer for three cycles with a pending producer.
    idle(); drv[0].iv = 1'b1; drv[0].ordy = 1'b0;
    for (int k = 1; k <= 4; k++) begin drv[0].id = 32'(100 + k); step(); end
    chk(0, "full occ", 128'(occ0), 128'(4));
    drv[0].id = 32'd105;
    for (int k = 0; k < 3; k++) begin
      step();
      chk(0, "blocked ready", 128'(obs_ir0), 128'(0));
    end
    chk(0, "blocked stall_count", 128'(stc0), 128'(3));
    chk(0, "frozen data", sd0, {32'd101, 32'd102, 32'd103, 32'd104});
    drv[0].ordy = 1'b1; prod = 105; exp_next = 101; n_xfer = 0;
    for (int k = 0; k < 16; k++) begin
      drv[0].iv = (prod <= 108); drv[0].id = 32'(prod);
      step();
      if (drv[0].iv && obs_ir0) prod++;
    end
    chk(0, "release transfers", 128'(n_xfer), 128'(8));

    // Stall stage 1 mid-stream.
    idle(); exp_next = 201; n_xfer = 0; drv[0].iv = 1'b1;
    drv[0].id = 32'd201; step();
    drv[0].id = 32'd202; step();
    drv[0].stl = 4'b0010; drv[0].id = 32'd203;
    for (int k = 0; k < 2; k++) begin
      step();
      chk(0, "stall1 ready", 128'(obs_ir0), 128'(0));
      chk(0, "stall1 bubble", 128'(sv0[2]), 128'(0));
      chk(0, "stall1 s0", 128'(sd0[31:0]), 128'(202));
      chk(0, "stall1 s1", 128'(sd0[63:32]), 128'(201));
    end
    drv[0].stl = '0; prod = 203;
    for (int k = 0; k < 14; k++) begin
      drv[0].iv = (prod <= 206); drv[0].id = 32'(prod);
      step();
      if (drv[0].iv && obs_ir0) prod++;
    end
    chk(0, "stall1 transfers", 128'(n_xfer), 128'(6));

    // Branch flush of stages 0-1; the older item still moves on.
    order_on = 1'b0; idle(); drv[0].iv = 1'b1;
    drv[0].id = 32'hB; step();
    drv[0].id = 32'hA; step();
    drv[0].iv = 1'b0; drv[0].fl = 4'b0011; step();
    chk(0, "flush valid", 128'(sv0), 128'(4'b0100));
    chk(0, "flush s2 data", 128'(sd0[95:64]), 128'(32'hB));
    chk(0, "flush s0s1 data", 128'(sd0[63:0]), 128'(0));
    chk(0, "flush occ", 128'(occ0), 128'(1));
    drv[0].fl = '0; step();
    chk(0, "pre retire", 128'(ret0), 128'(22));
    drv[0].stl = 4'b1000; drv[0].fl = 4'b1000; step();
    chk(0, "flush+stall last valid", 128'(sv0[3]), 128'(0));
    chk(0, "flush+stall last data", 128'(sd0[127:96]), 128'(0));
    chk(0, "flush+stall retired", 128'(ret0), 128'(22));

    // Random traffic on both instances against the model.
    for (int k = 0; k < 400; k++) begin
      for (int m = 0; m < 2; m++) begin
        drv[m].iv = ($urandom_range(3) != 0); drv[m].id = $urandom;
        drv[m].ordy = ($urandom_range(3) != 0);
        drv[m].stl = '0; drv[m].fl = '0;
        for (int i = 0; i < ms[m]; i++) begin
          drv[m].stl[i] = ($urandom_range(7) == 0);
          drv[m].fl[i]  = ($urandom_range(15) == 0);
        end
      end
      step();
    end
    chk(1, "sat retired", 128'(ret1), 128'(4'hF));
    chk(1, "sat stall", 128'(stc1), 128'(4'hF));

    // Drive the 16-bit stall counter into saturation.
    idle(); drv[0].fl = 4'hF; step();
    drv[0].fl = '0; drv[0].iv = 1'b1; drv[0].ordy = 1'b0;
    for (int k = 0; k < 65540; k++) begin drv[0].id = 32'(k); step(); end
    chk(0, "sat stall_count", 128'(stc0), 128'(16'hFFFF));
    chk(0, "sat occ", 128'(occ0), 128'(4));

    // Asynchronous reset between edges with a full, stalled pipe.
    #2;
    reset = 1'b0;
    #1;
    model_reset(0); model_reset(1);
    check_state(0); check_state(1);
    chk(0, "async in_ready", 128'(if0.in_ready), 128'(1));
    chk(0, "async stall_count", 128'(stc0), 128'(0));
    idle(); apply();
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_state(0); check_state(1);
    drv[0].iv = 1'b1; drv[0].id = 32'h55; step();
    chk(0, "post reset load", 128'(sv0), 128'(4'b0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
